// File: rtl/acq_ctrl_pkg.sv
// Shared definitions for the acquisition run controller.
//   - acq_state_e         : FSM state encoding, also driven on the state output
//   - ARM_CYCLES_DEFAULT  : default number of cycles acq_resetn is held low in ARM
//   - CNT_W / TIME_W      : widths of packet/run fields and of cycle-count fields
//   - last_packet_index() : converts a packet count into the acquisition block's
//                           "number_of_packet" encoding (count - 1, 0 treated as 1)
package acq_ctrl_pkg;

    localparam int ARM_CYCLES_DEFAULT = 16;
    localparam int CNT_W              = 16;
    localparam int TIME_W             = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_GAP   = 3'd3,
        ST_ERROR = 3'd4
    } acq_state_e;

    function automatic logic [CNT_W-1:0] last_packet_index(input logic [CNT_W-1:0] packets);
        return (packets == '0) ? '0 : packets - CNT_W'(1);
    endfunction

endpackage

// File: rtl/acq_watchdog.sv
// Stall watchdog for the RUN phase.
// Ports:
//   master_clock, resetn : clock and synchronous active-low reset
//   clear                : zero the counter (outside RUN and on every beat)
//   tick                 : count one idle cycle
//   limit                : stall limit in cycles, 0 disables the watchdog
//   expired              : the count reaches limit on this clock edge
// expired is asserted in the cycle whose edge would bring the count to limit,
// so the controller leaves RUN exactly limit cycles after the last beat.
module acq_watchdog
    import acq_ctrl_pkg::*;
(
    input  logic              master_clock,
    input  logic              resetn,
    input  logic              clear,
    input  logic              tick,
    input  logic [TIME_W-1:0] limit,
    output logic              expired
);

    logic [TIME_W-1:0] count_q;
    logic [TIME_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + TIME_W'(1);
        end
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = tick && !clear && (limit != '0) && (count_q + TIME_W'(1) == limit);

endmodule

// File: rtl/acq_run_controller.sv
// Sequences repeated acquisition runs: ARM (acquisition held in reset),
// RUN (acquisition released until a tlast beat), GAP (pause between runs).
// Ports:
//   master_clock, resetn            : clock, synchronous active-low reset
//   start, stop                     : single-cycle command pulses
//   cfg_raw/packets/runs/gap/timeout: run configuration, latched on start
//   mon_tvalid/tready/tlast         : passive tap of the acquisition AXIS output
//   acq_resetn, send_raw_data,
//   number_of_packet                : controls for the acquisition block
//   busy, done, timeout_err,
//   run_index, state                : status; state is the raw FSM encoding
// The monitor tap follows AXIS valid/ready rules: a beat is transferred only in
// a cycle with mon_tvalid and mon_tready both high; mon_tlast is meaningful only
// on such a beat. The controller never drives the stream, it only observes it.
module acq_run_controller
    import acq_ctrl_pkg::*;
#(
    parameter int ARM_CYCLES = ARM_CYCLES_DEFAULT
) (
    input  logic              master_clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_raw,
    input  logic [CNT_W-1:0]  cfg_packets,
    input  logic [CNT_W-1:0]  cfg_runs,
    input  logic [TIME_W-1:0] cfg_gap,
    input  logic [TIME_W-1:0] cfg_timeout,
    input  logic              mon_tvalid,
    input  logic              mon_tready,
    input  logic              mon_tlast,
    output logic              acq_resetn,
    output logic              send_raw_data,
    output logic [CNT_W-1:0]  number_of_packet,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  run_index,
    output logic [2:0]        state
);

    acq_state_e        state_q, state_d;
    logic [TIME_W-1:0] phase_cnt_q, phase_cnt_d;   // shared by ARM and GAP
    logic [CNT_W-1:0]  run_index_q, run_index_d;
    logic              stop_pending_q, stop_pending_d;
    logic              done_q, done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              raw_q, raw_d;
    logic [CNT_W-1:0]  last_pkt_q, last_pkt_d;
    logic [CNT_W-1:0]  runs_q, runs_d;
    logic [TIME_W-1:0] gap_q, gap_d;
    logic [TIME_W-1:0] timeout_q, timeout_d;

    logic              beat;
    logic              run_end;
    logic              wd_expired;
    logic [TIME_W-1:0] gap_last;
    logic              final_run;

    assign beat     = mon_tvalid && mon_tready;
    assign run_end  = beat && mon_tlast && (state_q == ST_RUN);
    assign gap_last = (gap_q == '0) ? '0 : gap_q - TIME_W'(1);
    // Completing run number run_index_q+1 exhausts a finite run budget.
    assign final_run = (runs_q != '0) && (run_index_q + CNT_W'(1) == runs_q);

    acq_watchdog u_watchdog (
        .master_clock (master_clock),
        .resetn       (resetn),
        .clear        ((state_q != ST_RUN) || beat),
        .tick         (state_q == ST_RUN),
        .limit        (timeout_q),
        .expired      (wd_expired)
    );

    always_comb begin
        state_d        = state_q;
        phase_cnt_d    = phase_cnt_q;
        run_index_d    = run_index_q;
        stop_pending_d = stop_pending_q;
        done_d         = 1'b0;
        timeout_err_d  = timeout_err_q;
        raw_d          = raw_q;
        last_pkt_d     = last_pkt_q;
        runs_d         = runs_q;
        gap_d          = gap_q;
        timeout_d      = timeout_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                // stop beats start; from ERROR it returns to IDLE keeping timeout_err.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    raw_d         = cfg_raw;
                    last_pkt_d    = last_packet_index(cfg_packets);
                    runs_d        = cfg_runs;
                    gap_d         = cfg_gap;
                    timeout_d     = cfg_timeout;
                    run_index_d   = '0;
                    timeout_err_d = 1'b0;
                    phase_cnt_d   = '0;
                    state_d       = ST_ARM;
                end
            end
            ST_ARM: begin
                if (stop) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (phase_cnt_q == TIME_W'(ARM_CYCLES - 1)) begin
                    phase_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    phase_cnt_d = phase_cnt_q + TIME_W'(1);
                end
            end
            ST_RUN: begin
                // A run end takes priority over a watchdog expiry in the same cycle.
                if (run_end) begin
                    run_index_d    = run_index_q + CNT_W'(1);
                    stop_pending_d = 1'b0;
                    phase_cnt_d    = '0;
                    if (stop || stop_pending_q || final_run) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (wd_expired) begin
                    stop_pending_d = 1'b0;
                    timeout_err_d  = 1'b1;
                    state_d        = ST_ERROR;
                end else if (stop) begin
                    stop_pending_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (phase_cnt_q == gap_last) begin
                    phase_cnt_d = '0;
                    state_d     = ST_ARM;
                end else begin
                    phase_cnt_d = phase_cnt_q + TIME_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge master_clock) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            phase_cnt_q    <= '0;
            run_index_q    <= '0;
            stop_pending_q <= 1'b0;
            done_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            raw_q          <= 1'b0;
            last_pkt_q     <= '0;
            runs_q         <= '0;
            gap_q          <= '0;
            timeout_q      <= '0;
        end else begin
            state_q        <= state_d;
            phase_cnt_q    <= phase_cnt_d;
            run_index_q    <= run_index_d;
            stop_pending_q <= stop_pending_d;
            done_q         <= done_d;
            timeout_err_q  <= timeout_err_d;
            raw_q          <= raw_d;
            last_pkt_q     <= last_pkt_d;
            runs_q         <= runs_d;
            gap_q          <= gap_d;
            timeout_q      <= timeout_d;
        end
    end

    assign acq_resetn       = (state_q == ST_RUN);
    assign busy             = (state_q == ST_ARM) || (state_q == ST_RUN) || (state_q == ST_GAP);
    assign send_raw_data    = raw_q;
    assign number_of_packet = last_pkt_q;
    assign done             = done_q;
    assign timeout_err      = timeout_err_q;
    assign run_index        = run_index_q;
    assign state            = state_q;

endmodule

// File: tb/tb_acq_run_controller.sv
// Bench for acq_run_controller: reset checks, a table of run configurations,
// randomized configurations with a phase-length reference model, and
// hand-written sequences for stop/timeout/reset corner cases.
module tb_acq_run_controller;

    localparam int ARM_N = 16;

    typedef struct {
        logic        raw;
        logic [15:0] packets;
        logic [15:0] runs;
        logic [31:0] gap;
        logic [31:0] timeout;
        logic [15:0] exp_nop;
    } vec_t;

    logic        master_clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        cfg_raw;
    logic [15:0] cfg_packets;
    logic [15:0] cfg_runs;
    logic [31:0] cfg_gap;
    logic [31:0] cfg_timeout;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic        acq_resetn;
    logic        send_raw_data;
    logic [15:0] number_of_packet;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] run_index;
    logic [2:0]  state;

    int n_vec = 0;
    int n_err = 0;

    always #5 master_clock = ~master_clock;

    acq_run_controller #(.ARM_CYCLES(ARM_N)) dut (
        .master_clock     (master_clock),
        .resetn           (resetn),
        .start            (start),
        .stop             (stop),
        .cfg_raw          (cfg_raw),
        .cfg_packets      (cfg_packets),
        .cfg_runs         (cfg_runs),
        .cfg_gap          (cfg_gap),
        .cfg_timeout      (cfg_timeout),
        .mon_tvalid       (mon_tvalid),
        .mon_tready       (mon_tready),
        .mon_tlast        (mon_tlast),
        .acq_resetn       (acq_resetn),
        .send_raw_data    (send_raw_data),
        .number_of_packet (number_of_packet),
        .busy             (busy),
        .done             (done),
        .timeout_err      (timeout_err),
        .run_index        (run_index),
        .state            (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge master_clock);
        #1;
    endtask

    task automatic quiet();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    // Random stream activity that never forms a tlast beat.
    task automatic noise_no_last();
        mon_tvalid = 1'($urandom_range(0, 1));
        mon_tready = 1'($urandom_range(0, 1));
        mon_tlast  = 1'($urandom_range(0, 1));
        if (mon_tvalid && mon_tready) mon_tlast = 1'b0;
    endtask

    task automatic noise_any();
        mon_tvalid = 1'($urandom_range(0, 1));
        mon_tready = 1'($urandom_range(0, 1));
        mon_tlast  = 1'($urandom_range(0, 1));
    endtask

    task automatic beat_last();
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b1;
        cyc();
        quiet();
    endtask

    task automatic do_start(input logic raw, input logic [15:0] packets, input logic [15:0] runs,
                            input logic [31:0] gap, input logic [31:0] timeout);
        cfg_raw     = raw;
        cfg_packets = packets;
        cfg_runs    = runs;
        cfg_gap     = gap;
        cfg_timeout = timeout;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic scramble_cfg();
        cfg_raw     = 1'($urandom_range(0, 1));
        cfg_packets = 16'($urandom);
        cfg_runs    = 16'($urandom_range(0, 2));
        cfg_gap     = 32'($urandom_range(0, 40));
        cfg_timeout = 32'($urandom_range(1, 4));
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int k = 0;
        while (state !== s && k < 500) begin
            cyc();
            k++;
        end
        check(name, state, s);
    endtask

    // Runs one configuration to completion. The model predicts the sequence of
    // phases and their lengths: ARM_N cycles of ARM, then RUN for d+1 cycles
    // where the bench sends tlast on the (d+1)-th RUN cycle, then GAP for
    // max(gap,1) cycles between runs, ending in IDLE with one done pulse.
    task automatic run_scenario(input vec_t v, input string tag);
        int d_q[$];
        int exp_st[$];
        int exp_len[$];
        int got_st[$];
        int got_len[$];
        int cur_st, cur_len, countdown, runs_seen, dones, misc_err, k, n;
        countdown = 0;
        for (int r = 0; r < int'(v.runs); r++) begin
            int d = $urandom_range(0, 6);
            d_q.push_back(d);
            exp_st.push_back(1);
            exp_len.push_back(ARM_N);
            exp_st.push_back(2);
            exp_len.push_back(d + 1);
            if (r != int'(v.runs) - 1) begin
                exp_st.push_back(3);
                exp_len.push_back((v.gap == 0) ? 1 : int'(v.gap));
            end
        end
        quiet();
        check({tag, " idle before start"}, state, 0);
        do_start(v.raw, v.packets, v.runs, v.gap, v.timeout);
        cur_st = int'(state);
        cur_len = 0;
        runs_seen = 0;
        dones = 0;
        misc_err = 0;
        k = 0;
        while (state != 3'd0 && k < 3000) begin
            if (int'(state) == cur_st) begin
                cur_len++;
            end else begin
                got_st.push_back(cur_st);
                got_len.push_back(cur_len);
                cur_st = int'(state);
                cur_len = 1;
            end
            if (done !== 1'b0) dones++;
            if (acq_resetn !== (state == 3'd2)) misc_err++;
            if (busy !== (state == 3'd1 || state == 3'd2 || state == 3'd3)) misc_err++;
            if (state == 3'd2) begin
                if (cur_len == 1) begin
                    countdown = (d_q.size() > 0) ? d_q.pop_front() : 0;
                    check({tag, " run_index at run start"}, run_index, runs_seen);
                    check({tag, " number_of_packet"}, number_of_packet, v.exp_nop);
                    check({tag, " send_raw_data"}, send_raw_data, v.raw);
                    runs_seen++;
                end
                if (countdown == 0) begin
                    mon_tvalid = 1'b1;
                    mon_tready = 1'b1;
                    mon_tlast  = 1'b1;
                end else begin
                    noise_no_last();
                end
                countdown--;
            end else begin
                noise_any();
            end
            scramble_cfg();
            cyc();
            k++;
        end
        got_st.push_back(cur_st);
        got_len.push_back(cur_len);
        quiet();
        check({tag, " reached idle"}, state, 0);
        check({tag, " done on completion"}, done, 1);
        check({tag, " no early done"}, dones, 0);
        check({tag, " final run_index"}, run_index, v.runs);
        check({tag, " acq_resetn/busy vs phase"}, misc_err, 0);
        check({tag, " phase count"}, got_st.size(), exp_st.size());
        n = (got_st.size() < exp_st.size()) ? got_st.size() : exp_st.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " phase state"}, got_st[i], exp_st[i]);
            check({tag, " phase length"}, got_len[i], exp_len[i]);
        end
        cyc();
        check({tag, " done is a pulse"}, done, 0);
    endtask

    vec_t tbl[5];

    initial begin
        int k;
        vec_t v;
        resetn = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_raw = 1'b0;
        cfg_packets = '0;
        cfg_runs = '0;
        cfg_gap = '0;
        cfg_timeout = '0;
        quiet();

        // ---- reset values ----
        repeat (3) cyc();
        check("rst state", state, 0);
        check("rst acq_resetn", acq_resetn, 0);
        check("rst send_raw_data", send_raw_data, 0);
        check("rst number_of_packet", number_of_packet, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst run_index", run_index, 0);
        resetn = 1'b1;
        cyc();

        // ---- table-driven configurations ----
        tbl[0] = '{raw: 1'b0, packets: 16'd4,      runs: 16'd2, gap: 32'd10, timeout: 32'd0,    exp_nop: 16'd3};
        tbl[1] = '{raw: 1'b1, packets: 16'd0,      runs: 16'd1, gap: 32'd0,  timeout: 32'd0,    exp_nop: 16'd0};
        tbl[2] = '{raw: 1'b0, packets: 16'd1,      runs: 16'd3, gap: 32'd0,  timeout: 32'd50,   exp_nop: 16'd0};
        tbl[3] = '{raw: 1'b1, packets: 16'hFFFF,   runs: 16'd2, gap: 32'd1,  timeout: 32'd0,    exp_nop: 16'hFFFE};
        tbl[4] = '{raw: 1'b0, packets: 16'h8000,   runs: 16'd2, gap: 32'd3,  timeout: 32'd1000, exp_nop: 16'h7FFF};
        for (int i = 0; i < 5; i++) run_scenario(tbl[i], $sformatf("tbl%0d", i));

        // ---- randomized configurations ----
        for (int t = 0; t < 6; t++) begin
            v.raw     = 1'($urandom_range(0, 1));
            v.packets = 16'($urandom);
            v.runs    = 16'($urandom_range(1, 3));
            v.gap     = 32'($urandom_range(0, 4));
            v.timeout = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'd200;
            v.exp_nop = (v.packets == 16'd0) ? 16'd0 : v.packets - 16'd1;
            run_scenario(v, $sformatf("rnd%0d", t));
        end

        // ---- continuous mode, stop mid-run ----
        do_start(1'b0, 16'd5, 16'd0, 32'd2, 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_state(3'd2, "cont reach run");
            beat_last();
            check("cont gap visit", state, 3);
        end
        wait_state(3'd2, "cont reach run 6");
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("cont stop pending keeps run", state, 2);
        check("cont no done on stop", done, 0);
        cyc();
        cyc();
        beat_last();
        check("cont idle after tlast", state, 0);
        check("cont done", done, 1);
        check("cont run_index", run_index, 6);
        cyc();
        check("cont done is a pulse", done, 0);

        // ---- watchdog ----
        do_start(1'b1, 16'd2, 16'd0, 32'd0, 32'd100);
        wait_state(3'd2, "wd reach run");
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        mon_tlast  = 1'b0;
        cyc();
        mon_tready = 1'b0;
        k = 0;
        while (state == 3'd2 && k < 300) begin
            cyc();
            k++;
        end
        quiet();
        check("wd cycles to error", k, 100);
        check("wd state error", state, 4);
        check("wd timeout_err", timeout_err, 1);
        check("wd acq_resetn", acq_resetn, 0);
        check("wd busy", busy, 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("wd stop in error to idle", state, 0);
        check("wd timeout_err held", timeout_err, 1);
        do_start(1'b0, 16'd2, 16'd0, 32'd0, 32'd100);
        check("wd start clears timeout_err", timeout_err, 0);
        check("wd start to arm", state, 1);
        wait_state(3'd2, "wd reach run 2");
        repeat (99) cyc();
        beat_last();
        check("wd run end beats expiry", state, 3);
        check("wd no error on run end", timeout_err, 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("gap stop to idle", state, 0);
        check("gap stop done", done, 1);
        check("gap stop run_index unchanged", run_index, 1);

        // ---- stop corner cases ----
        cfg_runs = 16'd1;
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        check("start+stop in idle ignored", state, 0);
        check("start+stop busy", busy, 0);
        do_start(1'b0, 16'd3, 16'd0, 32'd0, 32'd0);
        wait_state(3'd2, "coinc reach run");
        stop = 1'b1;
        beat_last();
        stop = 1'b0;
        check("coinc stop+tlast idle", state, 0);
        check("coinc done", done, 1);
        check("coinc run_index", run_index, 1);
        cyc();
        check("coinc done is a pulse", done, 0);
        do_start(1'b0, 16'd3, 16'd0, 32'd0, 32'd0);
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("arm stop idle", state, 0);
        check("arm stop done", done, 1);
        check("arm stop run_index", run_index, 0);

        // ---- cfg change during run, then reset mid-run ----
        do_start(1'b1, 16'd8, 16'd0, 32'd5, 32'd0);
        wait_state(3'd2, "rst reach run");
        cfg_raw = 1'b0;
        cfg_packets = 16'd3;
        cyc();
        cyc();
        check("cfg change raw held", send_raw_data, 1);
        check("cfg change nop held", number_of_packet, 7);
        check("run acq_resetn high", acq_resetn, 1);
        resetn = 1'b0;
        cyc();
        check("midrst state", state, 0);
        check("midrst done", done, 0);
        cyc();
        cyc();
        check("midrst acq_resetn", acq_resetn, 0);
        check("midrst send_raw_data", send_raw_data, 0);
        check("midrst number_of_packet", number_of_packet, 0);
        check("midrst busy", busy, 0);
        check("midrst run_index", run_index, 0);
        check("midrst timeout_err", timeout_err, 0);
        resetn = 1'b1;
        cyc();
        check("after rst state", state, 0);
        check("after rst done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acq_run_controller.md
ACQ_RUN_CONTROLLER -- requirements
Module: acq_run_controller

Interface
REQ-001 SHALL have parameter ARM_CYCLES, default 16: cycles acq_resetn is held low in ARM before a run.
REQ-002 SHALL have port master_clock  in  1  clock; all logic on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports start  in  1 and stop  in  1  single-cycle command pulses.
REQ-005 SHALL have ports cfg_raw  in  1 (raw mode), cfg_packets  in  16 (packets per run), cfg_runs  in  16 (0 = continuous).
REQ-006 SHALL have ports cfg_gap  in  32 (inter-run gap, cycles) and cfg_timeout  in  32 (stall limit, cycles; 0 = disabled).
REQ-007 SHALL have ports mon_tvalid, mon_tready, mon_tlast  in  1 each: passive tap of the acquisition AXIS output.
REQ-008 SHALL have ports acq_resetn  out  1, send_raw_data  out  1, number_of_packet  out  16: drive the acquisition block.
REQ-009 SHALL have ports busy  out  1, done  out  1 (pulse), timeout_err  out  1 (sticky), run_index  out  16, state  out  3.

Function
REQ-010 SHALL implement states IDLE=0, ARM=1, RUN=2, GAP=3, ERROR=4; state output = current encoding.
REQ-011 SHALL accept start only in IDLE or ERROR; on acceptance latch all cfg_* into shadow registers, clear run_index and timeout_err, go to ARM.
REQ-012 SHALL ignore cfg_* changes after latching until the next accepted start.
REQ-013 SHALL drive acq_resetn=0 in IDLE, ARM, GAP, ERROR and acq_resetn=1 only in RUN.
REQ-014 SHALL stay in ARM exactly ARM_CYCLES cycles, then enter RUN.
REQ-015 SHALL drive send_raw_data = latched cfg_raw and number_of_packet = latched cfg_packets-1 (cfg_packets 0 treated as 1), registered, stable whenever acq_resetn=1.
REQ-016 SHALL define beat = mon_tvalid & mon_tready; run end = beat with mon_tlast=1 while in RUN.
REQ-017 On run end with latched cfg_runs != 0 and run_index+1 == cfg_runs: SHALL pulse done one cycle, increment run_index, go to IDLE.
REQ-018 On any other run end: SHALL increment run_index (wraps 16'hFFFF->0 in continuous mode) and go to GAP.
REQ-019 SHALL remain in GAP for latched cfg_gap cycles (0 = one cycle), then go to ARM.
REQ-020 Watchdog in RUN: counter clears on entering RUN and on every beat, increments otherwise; at count == cfg_timeout (non-zero) SHALL go to ERROR and set timeout_err.
REQ-021 timeout_err SHALL remain set until the next accepted start or reset.
REQ-022 stop in ARM or GAP SHALL go to IDLE next cycle with done pulse; no partial run counted.
REQ-023 stop in RUN SHALL set stop_pending; next run end SHALL pulse done, increment run_index, go to IDLE.
REQ-024 stop and run end in the same cycle SHALL behave as REQ-023 completed in that cycle (IDLE, done).
REQ-025 start and stop in the same cycle in IDLE SHALL be ignored (stop wins).
REQ-026 Watchdog expiry and run end in the same cycle: run end wins (no error).
REQ-027 stop in ERROR SHALL go to IDLE, timeout_err held.
REQ-028 busy SHALL be 1 in ARM, RUN, GAP; else 0.

Reset
REQ-029 resetn=0 SHALL force state IDLE, acq_resetn=0, send_raw_data=0, number_of_packet=0, busy=0, done=0, timeout_err=0, run_index=0, stop_pending=0, all counters 0.
REQ-030 Reset mid-run SHALL abort immediately with no done pulse.

Structure
REQ-031 Shared package acq_ctrl_pkg SHALL hold state encodings, ARM_CYCLES default, and 16/32-bit width constants.
REQ-032 Watchdog SHALL be sub-module acq_watchdog (clear, tick, limit, expired); everything else in one FSM.

Verification
REQ-033 cfg_packets=4, cfg_runs=2, cfg_gap=10, start -> number_of_packet=3; 16 cycles acq_resetn low; two tlast beats -> run_index 2, one done pulse, IDLE.
REQ-034 cfg_runs=0, 5 tlast beats, then stop mid-run -> GAP visits 5, IDLE after next tlast, run_index=6, done once.
REQ-035 cfg_timeout=100, tready held low in RUN -> ERROR exactly 100 cycles after last beat, timeout_err=1, acq_resetn=0; new start clears it.
REQ-036 stop coincident with tlast beat -> IDLE next cycle, done pulse, run_index+1; stop during GAP -> IDLE, run_index unchanged.
REQ-037 resetn low 3 cycles during RUN -> all outputs at reset values, no done; cfg change during RUN does not alter send_raw_data.
